// File: rtl/gps_stream_pkg.sv
// Stream constants shared by the TX sample packer and the RX sample unpacker.
// Bit ordering: the first sample bit in time lands in bit 0 of the first word.
package gps_stream_pkg;

    localparam int SAMPLE_W            = 3;
    localparam int WORD_W              = 16;
    localparam int SAMPLES_PER_3_WORDS = 16;

    // Accumulator holds at most WORD_W-1 bits between words; one incoming sample extends it.
    localparam int HOLD_W = WORD_W - 1;
    localparam int ACC_W  = WORD_W + SAMPLE_W - 1;

endpackage

// File: rtl/sample_packer.sv
// Packs a continuous stream of 3-bit samples LSB-first into 16-bit words,
// with a one-entry valid/ready output register and a zero-padding flush.
module sample_packer #(
    parameter int SAMPLE_W = gps_stream_pkg::SAMPLE_W,
    parameter int WORD_W   = gps_stream_pkg::WORD_W,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample_data,
    input  logic                flush,
    input  logic                word_ready,
    output logic                word_valid,
    output logic [WORD_W-1:0]   word_data,
    output logic [3:0]          bit_count,
    output logic                overflow,
    output logic [CNT_W-1:0]    word_count
);

    localparam int HOLD_W = WORD_W - 1;
    localparam int ACC_W  = WORD_W + SAMPLE_W - 1;

    logic [HOLD_W-1:0] acc_q, acc_d;
    logic [3:0]        bit_count_q, bit_count_d;
    logic              flush_pending_q, flush_pending_d;
    logic              word_valid_q, word_valid_d;
    logic [WORD_W-1:0] word_data_q, word_data_d;
    logic              overflow_q, overflow_d;
    logic [CNT_W-1:0]  word_count_q, word_count_d;

    logic [ACC_W-1:0]  acc_ext;
    logic [4:0]        n;
    logic              do_flush;
    logic              word_done;
    logic [WORD_W-1:0] word_new;
    logic              xfer;
    logic              slot_free;

    // Bits above bit_count are always zero, so a flushed word is zero-padded for free.
    always_comb begin
        acc_ext = {{(ACC_W-HOLD_W){1'b0}}, acc_q};
        n       = {1'b0, bit_count_q};
        if (sample_valid) begin
            acc_ext[bit_count_q +: SAMPLE_W] = sample_data;
            n = n + 5'(SAMPLE_W);
        end

        do_flush        = flush | flush_pending_q;
        word_done       = 1'b0;
        word_new        = acc_ext[WORD_W-1:0];
        acc_d           = acc_ext[HOLD_W-1:0];
        bit_count_d     = n[3:0];
        flush_pending_d = 1'b0;

        if (n >= 5'(WORD_W)) begin
            word_done       = 1'b1;
            acc_d           = HOLD_W'(acc_ext >> WORD_W);
            bit_count_d     = 4'(n - 5'(WORD_W));
            // Remainder bits of a flush that overran a word go out next cycle.
            flush_pending_d = do_flush && (n != 5'(WORD_W));
        end else if (do_flush && (n != 5'd0)) begin
            word_done   = 1'b1;
            acc_d       = '0;
            bit_count_d = '0;
        end
    end

    // Handshake: a word transfers on any posedge where word_valid and word_ready are
    // both high; word_valid never drops without a transfer and word_data is stable
    // while word_valid is high and word_ready is low.
    always_comb begin
        xfer      = word_valid_q & word_ready;
        slot_free = ~word_valid_q | word_ready;

        word_valid_d = word_valid_q & ~xfer;
        word_data_d  = word_data_q;
        overflow_d   = overflow_q;
        word_count_d = xfer ? word_count_q + CNT_W'(1) : word_count_q;

        if (word_done) begin
            if (slot_free) begin
                word_valid_d = 1'b1;
                word_data_d  = word_new;
            end else begin
                // Word is lost but the accumulator remainder keeps stream alignment.
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_q           <= '0;
            bit_count_q     <= '0;
            flush_pending_q <= 1'b0;
            word_valid_q    <= 1'b0;
            word_data_q     <= '0;
            overflow_q      <= 1'b0;
            word_count_q    <= '0;
        end else begin
            acc_q           <= acc_d;
            bit_count_q     <= bit_count_d;
            flush_pending_q <= flush_pending_d;
            word_valid_q    <= word_valid_d;
            word_data_q     <= word_data_d;
            overflow_q      <= overflow_d;
            word_count_q    <= word_count_d;
        end
    end

    assign word_valid = word_valid_q;
    assign word_data  = word_data_q;
    assign bit_count  = bit_count_q;
    assign overflow   = overflow_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_sample_packer.sv
// Bench for sample_packer: directed vectors, hand-written corner sequences and a
// random run checked against a bit-queue model of the packing and drop rules.
module tb_sample_packer;
    import gps_stream_pkg::*;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                sample_valid = 1'b0;
    logic [SAMPLE_W-1:0] sample_data = '0;
    logic                flush = 1'b0;
    logic                word_ready = 1'b0;
    logic                word_valid;
    logic [WORD_W-1:0]   word_data;
    logic [3:0]          bit_count;
    logic                overflow;
    logic [15:0]         word_count;

    sample_packer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .flush        (flush),
        .word_ready   (word_ready),
        .word_valid   (word_valid),
        .word_data    (word_data),
        .bit_count    (bit_count),
        .overflow     (overflow),
        .word_count   (word_count)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: stream bits as a queue, plus the single output slot.
    bit          m_bits[$];
    logic        m_pend;
    logic        m_hv;
    logic [15:0] m_hd;
    logic        m_ovf;
    logic [15:0] m_cnt;
    logic [WORD_W-1:0] exp_q[$];

    task automatic model_reset();
        m_bits.delete();
        m_pend = 1'b0;
        m_hv   = 1'b0;
        m_hd   = '0;
        m_ovf  = 1'b0;
        m_cnt  = '0;
        exp_q.delete();
    endtask

    // Effect of the coming posedge given the inputs presented this cycle.
    task automatic model_edge(input logic v, input logic [2:0] d, input logic f, input logic r);
        logic [15:0] w;
        bit have;
        bit xfer;
        bit do_f;
        w    = '0;
        have = 1'b0;
        xfer = m_hv && r;
        if (xfer) begin
            exp_q.push_back(m_hd);
            m_cnt = m_cnt + 16'd1;
        end
        if (v) for (int i = 0; i < 3; i++) m_bits.push_back(d[i]);
        do_f = f || m_pend;
        if (m_bits.size() >= 16) begin
            for (int i = 0; i < 16; i++) w[i] = m_bits.pop_front();
            have   = 1'b1;
            m_pend = do_f && (m_bits.size() > 0);
        end else begin
            if (do_f && m_bits.size() > 0) begin
                for (int i = 0; m_bits.size() > 0; i++) w[i] = m_bits.pop_front();
                have = 1'b1;
            end
            m_pend = 1'b0;
        end
        if (have) begin
            if (!m_hv || r) begin
                m_hv = 1'b1;
                m_hd = w;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (xfer) begin
            m_hv = 1'b0;
        end
    endtask

    // Scoreboard: every accepted word must be the next one the model released.
    always @(negedge clk) begin
        if (reset_n && word_valid && word_ready) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL sb_unexpected: got word 0x%0h expected none at %0t", word_data, $time);
            end else begin
                chk("sb_word", word_data, exp_q.pop_front());
            end
        end
    end

    // Checks the state left by the last edge, then presents new inputs for one cycle.
    task automatic step(input logic v, input logic [2:0] d, input logic f, input logic r);
        chk("bit_count", bit_count, m_bits.size());
        chk("overflow", overflow, m_ovf);
        chk("word_valid", word_valid, m_hv);
        if (m_hv) chk("word_data", word_data, m_hd);
        chk("word_count", word_count, m_cnt);
        sample_valid = v;
        sample_data  = d;
        flush        = f;
        word_ready   = r;
        model_edge(v, d, f, r);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n      = 1'b0;
        sample_valid = 1'b0;
        sample_data  = '0;
        flush        = 1'b0;
        word_ready   = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [17:0] samples;
        int          nsamp;
        logic        flush_last;
        logic [15:0] exp_word;
        logic [3:0]  exp_bc;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{ {3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1}, 6, 1'b0, 16'h58D1, 4'd2 };
        vecs[1] = '{ {3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7}, 6, 1'b0, 16'hFFFF, 4'd2 };
        vecs[2] = '{ {12'd0, 3'd3, 3'd5},                  2, 1'b1, 16'h001D, 4'd0 };
        vecs[3] = '{ {3'd7, 15'd0},                        6, 1'b0, 16'h8000, 4'd2 };
        vecs[4] = '{ {3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2}, 6, 1'b0, 16'h2492, 4'd2 };
        vecs[5] = '{ {15'd0, 3'd4},                        1, 1'b1, 16'h0004, 4'd0 };

        model_reset();
        do_reset();
        chk("reset_valid", word_valid, 0);
        chk("reset_data", word_data, 0);
        chk("reset_bc", bit_count, 0);
        chk("reset_ovf", overflow, 0);
        chk("reset_cnt", word_count, 0);

        // Directed vectors: word seen right after the completing sample's edge.
        for (int i = 0; i < 6; i++) begin
            vec_t v;
            v = vecs[i];
            do_reset();
            for (int k = 0; k < v.nsamp; k++)
                step(1'b1, v.samples[3*k +: 3], v.flush_last && (k == v.nsamp - 1), 1'b1);
            chk("vec_valid", word_valid, 1);
            chk("vec_word", word_data, v.exp_word);
            chk("vec_bc", bit_count, v.exp_bc);
            step(1'b0, 3'd0, 1'b0, 1'b1);
        end

        // 16 samples fill exactly three words.
        do_reset();
        for (int k = 0; k < 16; k++) step(1'b1, 3'd7, 1'b0, 1'b1);
        step(1'b0, 3'd0, 1'b0, 1'b1);
        chk("three_words_cnt", word_count, 3);
        chk("three_words_bc", bit_count, 0);

        // Second flush with nothing held emits nothing.
        do_reset();
        step(1'b1, 3'd5, 1'b0, 1'b1);
        step(1'b1, 3'd3, 1'b1, 1'b1);
        chk("flush_word", word_data, 16'h001D);
        step(1'b0, 3'd0, 1'b1, 1'b1);
        step(1'b0, 3'd0, 1'b0, 1'b1);
        chk("flush_empty_valid", word_valid, 0);
        chk("flush_empty_cnt", word_count, 1);

        // Stalled output: first word held, second dropped, stream stays aligned.
        do_reset();
        for (int k = 0; k < 11; k++) step(1'b1, 3'(k % 8), 1'b0, 1'b0);
        step(1'b0, 3'd0, 1'b0, 1'b0);
        chk("stall_held", word_data, 16'hC688);
        chk("stall_ovf", overflow, 1);
        chk("stall_bc", bit_count, 1);
        step(1'b0, 3'd0, 1'b0, 1'b1);
        chk("stall_cnt", word_count, 1);
        for (int k = 0; k < 20; k++) step(1'b1, 3'($urandom_range(0, 7)), 1'b0, 1'b1);
        step(1'b0, 3'd0, 1'b0, 1'b1);

        // Flush overrunning a word: full word, then remainder next cycle.
        do_reset();
        for (int k = 0; k < 5; k++) step(1'b1, 3'd7, 1'b0, 1'b1);
        chk("pend_bc15", bit_count, 15);
        step(1'b1, 3'd7, 1'b1, 1'b1);
        chk("pend_word1", word_data, 16'hFFFF);
        step(1'b0, 3'd0, 1'b0, 1'b1);
        chk("pend_word2", word_data, 16'h0003);
        chk("pend_bc0", bit_count, 0);
        step(1'b0, 3'd0, 1'b0, 1'b1);

        // Reset mid-word, then the stream restarts cleanly.
        do_reset();
        for (int k = 0; k < 3; k++) step(1'b1, 3'd5, 1'b0, 1'b0);
        chk("mid_bc9", bit_count, 9);
        do_reset();
        chk("mid_rst_bc", bit_count, 0);
        chk("mid_rst_valid", word_valid, 0);
        for (int k = 1; k <= 6; k++) step(1'b1, 3'(k), 1'b0, 1'b1);
        chk("mid_word", word_data, 16'h58D1);
        step(1'b0, 3'd0, 1'b0, 1'b1);

        // Random traffic with random back-pressure and occasional flushes.
        do_reset();
        for (int c = 0; c < 4000; c++)
            step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                 $urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0);
        do_reset();
        for (int c = 0; c < 3000; c++)
            step($urandom_range(0, 1) != 0, 3'($urandom_range(0, 7)),
                 $urandom_range(0, 15) == 0, $urandom_range(0, 15) != 0);
        for (int c = 0; c < 4; c++) step(1'b0, 3'd0, 1'b0, 1'b1);
        chk("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
